// File: rtl/ysyx_2022040010_icache_pkg.sv
// Shared geometry, address-field helpers and FSM encodings for the
// direct-mapped instruction cache.
package ysyx_2022040010_icache_pkg;

  localparam int ICACHE_LINES = 64;  // default number of lines
  localparam int ICACHE_BEATS = 2;   // default 64-bit beats per line
  localparam int BEAT_BITS    = 64;
  localparam int WORD_BITS    = 32;
  localparam int ADDR_BITS    = 32;  // only addr[31:0] takes part in lookup
  localparam int OFFSET_LSB   = 2;   // addr[1:0] is ignored

  // Bits of word offset inside a line (addr[3:2] for a 16-byte line).
  function automatic int word_off_bits(input int beats);
    return $clog2(beats * 2);
  endfunction

  // Bits of byte offset inside a line; the index field starts here (4).
  function automatic int line_off_bits(input int beats);
    return word_off_bits(beats) + OFFSET_LSB;
  endfunction

  // Bits of set index (addr[9:4] for 64 lines); the tag sits above it.
  function automatic int index_bits(input int lines);
    return $clog2(lines);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_REFILL = 2'd2,
    ST_DONE   = 2'd3
  } icache_state_e;

endpackage

// File: rtl/ysyx_2022040010_icache_fsm.sv
// Miss-handling controller: refill state, beat counter, deferred fence
// flag and the request/grant/beat handshake with memory.
module ysyx_2022040010_icache_fsm
  import ysyx_2022040010_icache_pkg::*;
#(
  parameter int BEAT_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss,        // IDLE lookup missed this cycle
  input  logic              fence_i,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic              mem_rlast,
  output logic              mem_req,
  output logic [BEAT_W-1:0] beat,        // slot for the incoming beat
  output logic              buf_we,      // capture mem_rdata into line buffer
  output logic              line_we,     // commit line buffer into arrays
  output logic              clear_all,   // drop every valid bit
  output logic              busy         // stall regardless of lookup
);

  icache_state_e     state_r, state_nxt_s;
  logic [BEAT_W-1:0] beat_r, beat_nxt_s;
  logic              fence_pend_r, fence_pend_nxt_s;

  // State, beat counter and pending-fence registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      beat_r       <= '0;
      fence_pend_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      beat_r       <= beat_nxt_s;
      fence_pend_r <= fence_pend_nxt_s;
    end
  end

  // Next state, beat/fence bookkeeping and handshake strobes.
  always_comb begin
    state_nxt_s      = state_r;
    beat_nxt_s       = beat_r;
    fence_pend_nxt_s = fence_pend_r;
    mem_req          = 1'b0;
    buf_we           = 1'b0;
    line_we          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // The pending fence is consumed by the clear cycle spent in IDLE;
        // lookups resume on the cycle after.
        fence_pend_nxt_s = 1'b0;
        if (fence_pend_r) begin
          state_nxt_s = ST_IDLE;
        end else if (miss) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        mem_req          = 1'b1;
        beat_nxt_s       = '0;
        fence_pend_nxt_s = fence_pend_r | fence_i;
        if (mem_gnt) begin
          state_nxt_s = ST_REFILL;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_REFILL: begin
        buf_we           = mem_rvalid;
        fence_pend_nxt_s = fence_pend_r | fence_i;
        if (mem_rvalid) begin
          beat_nxt_s = beat_r + BEAT_W'(1);
        end else begin
          beat_nxt_s = beat_r;
        end
        if (mem_rvalid && mem_rlast) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_REFILL;
        end
      end
      ST_DONE: begin
        line_we          = 1'b1;
        fence_pend_nxt_s = fence_pend_r | fence_i;
        state_nxt_s      = ST_IDLE;
      end
      default: begin
        state_nxt_s      = ST_IDLE;
        fence_pend_nxt_s = 1'b0;
      end
    endcase
  end

  assign beat      = beat_r;
  assign clear_all = (state_r == ST_IDLE) && (fence_pend_r || fence_i);
  assign busy      = (state_r != ST_IDLE) || fence_pend_r;

endmodule

// File: rtl/ysyx_2022040010_icache.sv
// Direct-mapped instruction cache: register-array storage, same-cycle hit
// path, and refill through the miss controller.
module ysyx_2022040010_icache
  import ysyx_2022040010_icache_pkg::*;
#(
  parameter int LINES = ICACHE_LINES,
  parameter int BEATS = ICACHE_BEATS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        isram_e,
  input  logic [63:0] isram_addr,
  input  logic        fence_i,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        stallreq,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  input  logic        mem_rlast
);

  localparam int LINE_W  = BEATS * BEAT_BITS;
  localparam int WOFF_W  = word_off_bits(BEATS);
  localparam int LOFF_W  = line_off_bits(BEATS);
  localparam int IDX_W   = index_bits(LINES);
  localparam int TAG_W   = ADDR_BITS - LOFF_W - IDX_W;
  localparam int IDX_LSB = LOFF_W;
  localparam int TAG_LSB = LOFF_W + IDX_W;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [LINES-1:0]           valid_r;
  logic [TAG_W-1:0]           tag_r  [LINES];
  logic [LINE_W-1:0]          data_r [LINES];
  logic [LINE_W-1:0]          line_buf_r;
  logic [ADDR_BITS-LOFF_W-1:0] miss_line_r;  // latched {tag, index}

  logic [WOFF_W-1:0] off_s;
  logic [IDX_W-1:0]  idx_s;
  logic [TAG_W-1:0]  tag_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic [TAG_W-1:0]  wr_tag_s;
  logic              hit_s;
  logic              miss_s;
  logic [BEAT_W-1:0] beat_s;
  logic              buf_we_s;
  logic              line_we_s;
  logic              clear_all_s;
  logic              busy_s;
  logic              unused_addr_s;

  assign off_s    = isram_addr[OFFSET_LSB +: WOFF_W];
  assign idx_s    = isram_addr[IDX_LSB +: IDX_W];
  assign tag_s    = isram_addr[TAG_LSB +: TAG_W];
  assign wr_idx_s = miss_line_r[IDX_W-1:0];
  assign wr_tag_s = miss_line_r[IDX_W +: TAG_W];
  assign hit_s    = valid_r[idx_s] && (tag_r[idx_s] == tag_s);

  // Byte-lane and upper address bits play no part in the lookup.
  assign unused_addr_s = ^{isram_addr[63:32], isram_addr[OFFSET_LSB-1:0]};

  ysyx_2022040010_icache_fsm #(
    .BEAT_W (BEAT_W)
  ) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .miss       (miss_s),
    .fence_i    (fence_i),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rlast  (mem_rlast),
    .mem_req    (mem_req),
    .beat       (beat_s),
    .buf_we     (buf_we_s),
    .line_we    (line_we_s),
    .clear_all  (clear_all_s),
    .busy       (busy_s)
  );

  // Lookup: same-cycle hit data, or stall while a refill/fence clear runs.
  always_comb begin
    inst       = 32'h0;
    inst_valid = 1'b0;
    stallreq   = 1'b0;
    miss_s     = 1'b0;
    if (rst) begin
      stallreq = 1'b0;
    end else if (busy_s) begin
      stallreq = 1'b1;
    end else if (isram_e) begin
      if (hit_s) begin
        inst       = data_r[idx_s][off_s*WORD_BITS +: WORD_BITS];
        inst_valid = 1'b1;
      end else begin
        stallreq = 1'b1;
        miss_s   = 1'b1;
      end
    end else begin
      stallreq = 1'b0;
    end
  end

  // Refill address is only driven while the request is outstanding.
  always_comb begin
    mem_addr = 64'h0;
    if (mem_req) begin
      mem_addr = {32'h0, miss_line_r, {LOFF_W{1'b0}}};
    end else begin
      mem_addr = 64'h0;
    end
  end

  // Capture the missing line address; later address changes do not matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_line_r <= '0;
    end else if (miss_s) begin
      miss_line_r <= isram_addr[ADDR_BITS-1:LOFF_W];
    end
  end

  // Assemble incoming beats; beat 0 lands in the low half of the line.
  always_ff @(posedge clk) begin
    if (buf_we_s) begin
      line_buf_r[beat_s*BEAT_BITS +: BEAT_BITS] <= mem_rdata;
    end
  end

  // Valid bits: cleared by reset or fence, set when a line is committed.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
    end else if (clear_all_s) begin
      valid_r <= '0;
    end else if (line_we_s) begin
      valid_r[wr_idx_s] <= 1'b1;
    end
  end

  // Tag and data arrays; contents are meaningless until valid is set.
  always_ff @(posedge clk) begin
    if (line_we_s) begin
      tag_r[wr_idx_s]  <= wr_tag_s;
      data_r[wr_idx_s] <= line_buf_r;
    end
  end

endmodule

// File: tb/tb_ysyx_2022040010_icache.sv
// Self-checking bench for the instruction cache: a vector table of fetches
// with expected stall counts, a scoreboard of expected instructions, a
// responsive memory model, and sequences for fence and reset corner cases.
module tb_ysyx_2022040010_icache;

  logic        clk;
  logic        rst;
  logic        isram_e;
  logic [63:0] isram_addr;
  logic        fence_i;
  logic [31:0] inst;
  logic        inst_valid;
  logic        stallreq;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        mem_rlast;

  int checks = 0;
  int errors = 0;

  int          gnt_delay = 0;
  int          gap       = 0;
  bit          resp_busy = 0;
  logic [63:0] cur_addr  = 64'h0;
  logic [31:0] sb_q[$];

  ysyx_2022040010_icache dut (
    .clk        (clk),
    .rst        (rst),
    .isram_e    (isram_e),
    .isram_addr (isram_addr),
    .fence_i    (fence_i),
    .inst       (inst),
    .inst_valid (inst_valid),
    .stallreq   (stallreq),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_rlast  (mem_rlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference memory image: the first line holds the program from the
  // bring-up test, everything else is an address-derived pattern.
  function automatic logic [31:0] ref_word(input logic [63:0] a);
    logic [31:0] w;
    if (a[31:4] == 28'h8000000) begin
      case (a[3:2])
        2'd0:    w = 32'h00100093;
        2'd1:    w = 32'h00000013;
        2'd2:    w = 32'h00200113;
        default: w = 32'h00000073;
      endcase
    end else begin
      w = {a[31:2], 2'b00} ^ 32'h5A5A0F0F;
    end
    return w;
  endfunction

  function automatic logic [63:0] ref_beat(input logic [63:0] line, input int b);
    logic [63:0] base;
    base = line + 64'(b * 8);
    return {ref_word(base + 64'd4), ref_word(base)};
  endfunction

  // Memory model: grants after gnt_delay cycles, then beat 0, gap idle
  // cycles, and beat 1 with rlast. Checks the request is held stable.
  initial begin : mem_model
    logic [63:0] exp_line;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 64'h0;
    mem_rlast  = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mem_req === 1'b1) begin
        resp_busy = 1'b1;
        exp_line  = {32'h0, cur_addr[31:4], 4'h0};
        chk("mem_addr_line", mem_addr, exp_line);
        for (int d = 0; d < gnt_delay; d++) begin
          @(posedge clk); #1;
          chk("mem_req_held", {63'h0, mem_req}, 64'h1);
          chk("mem_addr_held", mem_addr, exp_line);
        end
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = ref_beat(exp_line, 0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        mem_rdata  = 64'h0;
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
        end
        mem_rvalid = 1'b1;
        mem_rdata  = ref_beat(exp_line, 1);
        mem_rlast  = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        mem_rdata  = 64'h0;
        mem_rlast  = 1'b0;
        resp_busy  = 1'b0;
      end
    end
  end

  // Present one fetch until it hits; count stalled cycles on the way.
  // The expected instruction is queued at drive time and popped on hit.
  task automatic fetch(input logic [63:0] a, input logic fen, output int stalls);
    bit          ok;
    logic [31:0] exp;
    ok     = 1'b0;
    stalls = 0;
    sb_q.push_back(ref_word(a));
    @(posedge clk); #1;
    cur_addr   = a;
    isram_e    = 1'b1;
    isram_addr = a;
    fence_i    = fen;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (inst_valid === 1'b1) begin
        exp = sb_q.pop_front();
        chk("hit_inst", {32'h0, inst}, {32'h0, exp});
        chk("hit_stallreq", {63'h0, stallreq}, 64'h0);
        ok = 1'b1;
        break;
      end else if (stallreq === 1'b1) begin
        stalls++;
      end
      @(posedge clk); #1;
      fence_i = 1'b0;
    end
    if (!ok) begin
      chk("fetch_timeout", {63'h0, ok}, 64'h1);
      if (sb_q.size() > 0) exp = sb_q.pop_front();
    end
    @(posedge clk); #1;
    isram_e = 1'b0;
    fence_i = 1'b0;
  endtask

  typedef struct {
    logic [63:0] addr;
    int          stalls;  // miss: detect cycle + REQ + 2 beats + DONE = 5
  } vec_t;

  vec_t vecs[10];
  int   st;
  bit   seen;

  initial begin : main
    vecs[0] = '{64'h0000_0000_8000_0000, 5};  // cold miss
    vecs[1] = '{64'h0000_0000_8000_0004, 0};
    vecs[2] = '{64'h0000_0000_8000_000C, 0};
    vecs[3] = '{64'h0000_0000_8000_0008, 0};
    vecs[4] = '{64'h0000_0000_8000_0400, 5};  // same index, new tag
    vecs[5] = '{64'h0000_0000_8000_0404, 0};
    vecs[6] = '{64'h0000_0000_8000_0000, 5};  // evicted, misses again
    vecs[7] = '{64'h0000_0000_8000_0010, 5};  // index 1
    vecs[8] = '{64'hFFFF_FFFF_8000_0013, 0};  // upper and low bits ignored
    vecs[9] = '{64'h0000_0000_8000_0400, 5};  // evicted by vecs[6]

    rst        = 1'b1;
    isram_e    = 1'b1;
    isram_addr = 64'h0000_0000_8000_0000;
    fence_i    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_inst", {32'h0, inst}, 64'h0);
    chk("rst_inst_valid", {63'h0, inst_valid}, 64'h0);
    chk("rst_stallreq", {63'h0, stallreq}, 64'h0);
    chk("rst_mem_req", {63'h0, mem_req}, 64'h0);
    chk("rst_mem_addr", mem_addr, 64'h0);
    @(posedge clk); #1;
    rst     = 1'b0;
    isram_e = 1'b0;

    foreach (vecs[i]) begin
      fetch(vecs[i].addr, 1'b0, st);
      chk($sformatf("vec%0d_stalls", i), 64'(st), 64'(vecs[i].stalls));
    end

    // Fetch disabled on a cached address: no output, no stall.
    @(posedge clk); #1;
    isram_e    = 1'b0;
    isram_addr = 64'h0000_0000_8000_0000;
    @(negedge clk);
    chk("dis_inst", {32'h0, inst}, 64'h0);
    chk("dis_inst_valid", {63'h0, inst_valid}, 64'h0);
    chk("dis_stallreq", {63'h0, stallreq}, 64'h0);

    // Slow memory: 6 REQ cycles, 5 REFILL cycles, + detect + DONE = 13.
    gnt_delay = 5;
    gap       = 3;
    fetch(64'h0000_0000_8000_0020, 1'b0, st);
    chk("slow_stalls", 64'(st), 64'd13);
    gnt_delay = 0;
    gap       = 0;

    // fence_i during REFILL: line completes (5), clear cycle (1), then the
    // re-presented fetch finds everything invalid and refills again (5).
    seen = 1'b0;
    fork
      fetch(64'h0000_0000_8000_0040, 1'b0, st);
      begin
        for (int c = 0; c < 40; c++) begin
          @(posedge clk); #2;
          if (mem_rvalid === 1'b1) begin
            fence_i = 1'b1;
            seen    = 1'b1;
            break;
          end
        end
        @(posedge clk); #1;
        fence_i = 1'b0;
      end
    join
    chk("fence_refill_seen", {63'h0, seen}, 64'h1);
    chk("fence_refill_stalls", 64'(st), 64'd11);
    fetch(64'h0000_0000_8000_0000, 1'b0, st);
    chk("fence_then_miss", 64'(st), 64'd5);

    // fence_i in IDLE: the same-cycle hit still returns the old line.
    fetch(64'h0000_0000_8000_0000, 1'b1, st);
    chk("fence_idle_hit", 64'(st), 64'd0);
    fetch(64'h0000_0000_8000_0004, 1'b0, st);
    chk("fence_idle_miss", 64'(st), 64'd5);

    // Reset after beat 0 of a refill; the late beat 1 must be ignored.
    gap = 3;
    @(posedge clk); #1;
    cur_addr   = 64'h0000_0000_8000_0050;
    isram_e    = 1'b1;
    isram_addr = cur_addr;
    seen       = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #2;
      if (mem_rvalid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rst_beat0_seen", {63'h0, seen}, 64'h1);
    @(posedge clk); #1;
    rst     = 1'b1;
    isram_e = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_mem_req", {63'h0, mem_req}, 64'h0);
    chk("rst_mid_stallreq", {63'h0, stallreq}, 64'h0);
    for (int c = 0; c < 20; c++) begin
      if (!resp_busy) break;
      @(posedge clk); #1;
    end
    chk("rst_resp_done", {63'h0, resp_busy}, 64'h0);
    @(negedge clk);
    chk("rst_late_beat_idle", {63'h0, mem_req}, 64'h0);
    gap = 0;
    fetch(64'h0000_0000_8000_0050, 1'b0, st);
    chk("rst_then_miss", 64'(st), 64'd5);
    fetch(64'h0000_0000_8000_005C, 1'b0, st);
    chk("rst_refill_hit", 64'(st), 64'd0);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
